// File: rtl/vga_timer_sequencer.sv
// Avalon-MM master that runs the system interval timer in continuous-interrupt mode,
// turning each serviced timeout into a one-cycle tick and reading counter snapshots on demand.
module vga_timer_sequencer #(
  parameter int TICK_W     = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period,
  input  logic              snap_req,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              timer_irq
);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;

  localparam logic [15:0] CTRL_RUN  = 16'h0007;  // ITO | CONT | START
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR_ST,
    S_WR_STOP, S_SNAP_WR, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_CAP
  } state_t;

  state_t      state, state_d;
  logic [31:0] load_q;
  logic [15:0] snap_lo;
  logic [31:0] snap_hold;
  logic [31:0] period_clamped;
  logic [31:0] load_value;
  logic        accept_start;

  assign period_clamped = (period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period;
  assign load_value     = period_clamped - 32'd1;

  // A start in RUN loses to a pending timeout, so it is only taken when irq is low.
  assign accept_start = start && ((state == S_IDLE) || (state == S_RUN && !timer_irq));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:     if (start) state_d = S_WR_PL;
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CTRL;
      S_WR_CTRL:  state_d = S_RUN;
      S_RUN: begin
        if (timer_irq)     state_d = S_CLR_ST;
        else if (start)    state_d = S_WR_PL;
        else if (stop)     state_d = S_WR_STOP;
        else if (snap_req) state_d = S_SNAP_WR;
      end
      S_CLR_ST:   state_d = S_RUN;
      S_WR_STOP:  state_d = S_IDLE;
      S_SNAP_WR:  state_d = S_SNAP_RDL;
      S_SNAP_RDL: state_d = S_SNAP_RDH;
      S_SNAP_RDH: state_d = S_SNAP_CAP;
      S_SNAP_CAP: state_d = S_RUN;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      load_q     <= '0;
      running    <= 1'b0;
      tick_count <= '0;
      snap_lo    <= '0;
      snap_hold  <= '0;
    end else begin
      state <= state_d;
      if (accept_start) begin
        load_q     <= load_value;
        tick_count <= '0;
        running    <= 1'b0;
      end
      if (state == S_WR_CTRL) running <= 1'b1;
      if (state == S_WR_STOP) running <= 1'b0;
      if (state == S_CLR_ST)  tick_count <= tick_count + 1'b1;
      if (state == S_SNAP_RDH) snap_lo <= avm_readdata;
      if (state == S_SNAP_CAP) snap_hold <= {avm_readdata, snap_lo};
    end
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
    unique case (state)
      S_WR_PL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = REG_PERIOD_L; avm_writedata = load_q[15:0];
      end
      S_WR_PH: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = REG_PERIOD_H; avm_writedata = load_q[31:16];
      end
      S_WR_CTRL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = REG_CONTROL; avm_writedata = CTRL_RUN;
      end
      S_CLR_ST: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = REG_STATUS;
      end
      S_WR_STOP: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = REG_CONTROL; avm_writedata = CTRL_STOP;
      end
      S_SNAP_WR: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = REG_SNAP_L;
      end
      S_SNAP_RDL: begin
        avm_chipselect = 1'b1; avm_address = REG_SNAP_L;
      end
      S_SNAP_RDH: begin
        avm_chipselect = 1'b1; avm_address = REG_SNAP_H;
      end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE) && (state != S_RUN);
  assign tick       = (state == S_CLR_ST);
  assign snap_valid = (state == S_SNAP_CAP);
  // The high half arrives in the valid cycle itself, so it is passed through while valid.
  assign snap_value = snap_valid ? {avm_readdata, snap_lo} : snap_hold;

endmodule
